l2send: RTL and testbench
=========================

// Module: l2send
// PURPOSE
//  L2 bus transmitter; the sending end of the protocol that l2recv receives and snoops.
//  Queues L2-originated transactions and drives them onto the shared L2 bus in its own TDM frame:
//   - requests BUSRD/BUSRDX/BUSUPGR
//   - data transfers FILL/FLUSH
//  Allocates request tags, retries on nack, and reports completion to the L2 controller.
// PARAMETERS
//  NODE_ID    0  2-bit bus node number; selects the owned frame and bus_tag[4:3]
//  NUM_NODES  4  frames per rotation, 1..4
//  QDEPTH     2  request queue entries, power of 2, >=2
// PORTS
//  clk                   in   1    clock
//  rst                   in   1    synchronous active-high reset
//  l2_l2send_valid       in   1    L2 presents a transaction
//  l2send_l2_ready       out  1    queue not full; push = valid&ready
//  l2_l2send_cmd         in   3    0 BUSRD, 1 BUSRDX, 2 BUSUPGR, 3 FILL, 4 FLUSH
//  l2_l2send_tag         in   5    requester tag; FILL only
//  l2_l2send_addr        in   26   line address [31:6]
//  l2_l2send_data        in   512  line data, beat i = [64i+63:64i]; FILL/FLUSH only
//  l2send_l2_done        out  1    one-cycle pulse: head transaction completed unnacked
//  l2recv_l2send_free    in   1    request tag returned (fill received)
//  l2recv_l2send_freeidx in   3    index of returned tag
//  l2send_bus_valid      out  1    driving a beat this cycle
//  l2send_bus_cmd        out  3    command
//  l2send_bus_tag        out  5    tag
//  l2send_bus_addr       out  30   word address [31:2]
//  l2send_bus_data       out  64   data beat
//  bus_nack              in   1    shared nack line
// BEHAVIOUR
//  Timebase
//   - cyc_r: 3-bit beat counter; frame_r: frame counter mod NUM_NODES, increments when cyc_r==7.
//   - Both reset to 0, matching l2recv bus_cycle_r. Own frame: frame_r==NODE_ID.
//  Queue
//   - QDEPTH-entry FIFO holding {cmd, tag, addr, data}. ready = !full, also while rst is low.
//   - A push into a full queue is not accepted (ready=0).
//   - A pop happens only at cyc_r==7 of an own frame whose issue succeeded.
//  Tags
//   - 8-bit free bitmap, reset all free.
//   - BUSRD/BUSRDX take the lowest free index at launch.
//   - bus_tag = {NODE_ID, idx}; the tag is kept across retries.
//   - Freed by l2recv_l2send_free. Allocation and freeing in the same cycle: the freed index is not reusable until the next cycle.
//   - BUSUPGR/FLUSH send tag {NODE_ID, 3'b000} and allocate nothing. FILL sends l2_l2send_tag.
//  FSM IDLE -> XMIT -> IDLE
//   - Launch: in IDLE at cyc_r==7 when the next frame is own, head valid, and tag available if needed.
//     Output registers load so beat 0 appears when cyc_r==0.
//   - No free tag for BUSRD/BUSRDX: the frame is skipped (bus idle), no reorder.
//   - XMIT, request cmds (0-2): bus_valid only at beat 0; addr = {line, 4'b0}.
//   - XMIT, data cmds (3-4): 8 beats, cyc 0..7; beat i addr = {line, i[2:0], 1'b0}, data beat i.
//   - nack_r samples bus_nack at cyc_r==2 of an own XMIT frame.
//   - At cyc_r==7: nack_r=0 -> pop, pulse done. nack_r=1 -> head stays, retry in next own frame (tag held).
//   - A data frame always completes all 8 beats even when nacked.
//   - bus_nack outside beat 2 of an own frame is ignored.
//  Outputs
//   - When not driving: all l2send_bus_* = 0.
//   - Reset value of every output is 0, except l2send_l2_ready = 1.
//   - Latency from push into an empty queue to beat 0 is the wait to the next own frame, at most 8*NUM_NODES cycles.
//   - NUM_NODES=1: every frame is own; back-to-back transactions are allowed.
//  Reset
//   - Reset mid-frame aborts immediately: bus outputs 0 the next cycle.
//   - Queue emptied, tags all freed, counters 0, FSM IDLE.
// CONFIGURATION
//  L2SEND_NACKCNT_EN defined:
//   - Adds out port l2send_nackcnt[15:0], a saturating count of nacked frames (stops at 16'hFFFF), reset 0.
//  Undefined:
//   - No port, no counter; behaviour otherwise identical.
// TESTING
//  - NODE_ID=1, push BUSRD addr 26'h123 at cyc 3 of frame 0
//     -> beat 0 of frame 1 (cycle 8): valid, cmd 0, tag 5'b01000, addr {26'h123,4'b0}
//     -> done pulse at cycle 15.
//  - NODE_ID=0, push FLUSH, data beats 64'hA0..A7
//     -> 8 consecutive beats in frame 0, addr[5:3] = 0..7, data A0..A7, done at cyc 7.
//  - BUSRDX with bus_nack=1 at beat 2 of the first own frame
//     -> no done, identical beat with the same tag one rotation (32 cycles) later, done after.
//  - Eight BUSRDs with no frees -> tags idx 0..7 issued; the ninth stalls (bus idle in own frames).
//     Free idx 3 -> the ninth issues with idx 3.
//  - Fill the queue to QDEPTH -> ready=0. One pop -> ready=1 the next cycle.
//  - Assert rst at beat 4 of a FLUSH frame -> beats 5-7 absent, ready=1, re-push issues with tag idx 0.
//     With L2SEND_NACKCNT_EN, three nacks -> nackcnt=3.

Source files
------------

// File: rtl/l2send.sv
// l2send: L2 bus transmitter. Queues L2 transactions and drives them onto the shared bus in this node's TDM frame.
// Optional build macro L2SEND_NACKCNT_EN adds the l2send_nackcnt saturating nacked-frame counter port.
module l2send #(
    parameter int NODE_ID   = 0,
    parameter int NUM_NODES = 4,
    parameter int QDEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         l2_l2send_valid,
    output logic         l2send_l2_ready,
    input  logic [2:0]   l2_l2send_cmd,
    input  logic [4:0]   l2_l2send_tag,
    input  logic [25:0]  l2_l2send_addr,
    input  logic [511:0] l2_l2send_data,
    output logic         l2send_l2_done,
    input  logic         l2recv_l2send_free,
    input  logic [2:0]   l2recv_l2send_freeidx,
    output logic         l2send_bus_valid,
    output logic [2:0]   l2send_bus_cmd,
    output logic [4:0]   l2send_bus_tag,
    output logic [29:0]  l2send_bus_addr,
    output logic [63:0]  l2send_bus_data,
    input  logic         bus_nack
`ifdef L2SEND_NACKCNT_EN
    ,
    output logic [15:0]  l2send_nackcnt
`endif
);
    localparam int         PW         = $clog2(QDEPTH);
    localparam int         CW         = PW + 1;
    localparam logic [1:0] NODE       = 2'(NODE_ID);
    localparam logic [1:0] LAST_FRAME = 2'(NUM_NODES - 1);
    localparam logic [2:0] CMD_BUSRD  = 3'd0;
    localparam logic [2:0] CMD_BUSRDX = 3'd1;
    localparam logic [2:0] CMD_FILL   = 3'd3;
    localparam logic [2:0] CMD_FLUSH  = 3'd4;

    typedef enum logic {S_IDLE, S_XMIT} state_t;

    state_t          state_r, state_nxt;
    logic [2:0]      cyc_r;
    logic [1:0]      frame_r;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [7:0]      free_r, free_nxt;
    logic            head_tag_vld_r;
    logic [2:0]      head_tag_idx_r;
    logic            nack_r;

    logic [2:0]      q_cmd  [QDEPTH];
    logic [4:0]      q_tag  [QDEPTH];
    logic [25:0]     q_addr [QDEPTH];
    logic [511:0]    q_data [QDEPTH];

    logic            push, pop, launch, alloc;
    logic            frame_end, next_own;
    logic [PW-1:0]   cand_ptr;
    logic            cand_valid, cand_held, cand_is_rd, cand_is_data, needs_tag;
    logic [2:0]      cand_cmd;
    logic [4:0]      cand_tag;
    logic            free_any;
    logic [2:0]      free_idx;
    logic [2:0]      head_cmd, next_beat;
    logic            head_is_data;
    logic [4:0]      head_bus_tag;
    logic [511:0]    head_data;

    assign l2send_l2_ready = (count != CW'(QDEPTH));
    assign push            = l2_l2send_valid && l2send_l2_ready;
    assign l2send_l2_done  = pop;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        frame_end    = (cyc_r == 3'd7);
        next_own     = (((frame_r == LAST_FRAME) ? 2'd0 : frame_r + 2'd1) == NODE);
        pop          = (state_r == S_XMIT) && frame_end && !nack_r;

        // At a frame boundary the launch candidate is the entry that will be head after any pop.
        cand_ptr     = pop ? rd_ptr + PW'(1) : rd_ptr;
        cand_valid   = pop ? (count > CW'(1)) : (count != '0);
        cand_cmd     = q_cmd[cand_ptr];
        cand_held    = !pop && head_tag_vld_r;
        cand_is_rd   = (cand_cmd == CMD_BUSRD) || (cand_cmd == CMD_BUSRDX);
        cand_is_data = (cand_cmd == CMD_FILL) || (cand_cmd == CMD_FLUSH);
        needs_tag    = cand_is_rd && !cand_held;

        free_any = 1'b0;
        free_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (free_r[i]) begin
                free_any = 1'b1;
                free_idx = 3'(i);
            end
        end

        launch = frame_end && next_own && cand_valid && (!needs_tag || free_any);
        alloc  = launch && needs_tag;

        if (cand_cmd == CMD_FILL)
            cand_tag = q_tag[cand_ptr];
        else if (cand_is_rd)
            cand_tag = {NODE, needs_tag ? free_idx : head_tag_idx_r};
        else
            cand_tag = {NODE, 3'b000};

        state_nxt = state_r;
        if (frame_end)
            state_nxt = launch ? S_XMIT : S_IDLE;

        // Freed index is applied after allocation, so it is only reusable next cycle.
        free_nxt = free_r;
        if (alloc)
            free_nxt[free_idx] = 1'b0;
        if (l2recv_l2send_free)
            free_nxt[l2recv_l2send_freeidx] = 1'b1;

        head_cmd     = q_cmd[rd_ptr];
        head_is_data = (head_cmd == CMD_FILL) || (head_cmd == CMD_FLUSH);
        head_bus_tag = (head_cmd == CMD_FILL) ? q_tag[rd_ptr] : {NODE, 3'b000};
        head_data    = q_data[rd_ptr];
        next_beat    = cyc_r + 3'd1;
    end

    // NOTE: queue storage is deliberately not reset; count and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            q_cmd[wr_ptr]  <= l2_l2send_cmd;
            q_tag[wr_ptr]  <= l2_l2send_tag;
            q_addr[wr_ptr] <= l2_l2send_addr;
            q_data[wr_ptr] <= l2_l2send_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= S_IDLE;
            cyc_r          <= 3'd0;
            frame_r        <= 2'd0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            free_r         <= '1;
            head_tag_vld_r <= 1'b0;
            head_tag_idx_r <= 3'd0;
            nack_r         <= 1'b0;
        end else begin
            state_r <= state_nxt;
            cyc_r   <= cyc_r + 3'd1;
            if (frame_end)
                frame_r <= (frame_r == LAST_FRAME) ? 2'd0 : frame_r + 2'd1;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count  <= count + CW'(push) - CW'(pop);
            free_r <= free_nxt;
            if (pop)
                head_tag_vld_r <= 1'b0;
            if (alloc) begin
                head_tag_vld_r <= 1'b1;
                head_tag_idx_r <= free_idx;
            end
            if ((state_r == S_XMIT) && (cyc_r == 3'd2))
                nack_r <= bus_nack;
        end
    end

    // Bus registers are loaded one cycle ahead so each beat appears on its own cyc_r value.
    always_ff @(posedge clk) begin
        if (rst) begin
            l2send_bus_valid <= 1'b0;
            l2send_bus_cmd   <= 3'd0;
            l2send_bus_tag   <= 5'd0;
            l2send_bus_addr  <= 30'd0;
            l2send_bus_data  <= 64'd0;
        end else if (launch) begin
            l2send_bus_valid <= 1'b1;
            l2send_bus_cmd   <= cand_cmd;
            l2send_bus_tag   <= cand_tag;
            l2send_bus_addr  <= {q_addr[cand_ptr], 4'b0000};
            l2send_bus_data  <= cand_is_data ? q_data[cand_ptr][63:0] : 64'd0;
        end else if ((state_r == S_XMIT) && !frame_end && head_is_data) begin
            l2send_bus_valid <= 1'b1;
            l2send_bus_cmd   <= head_cmd;
            l2send_bus_tag   <= head_bus_tag;
            l2send_bus_addr  <= {q_addr[rd_ptr], next_beat, 1'b0};
            l2send_bus_data  <= head_data[{next_beat, 6'b000000} +: 64];
        end else begin
            l2send_bus_valid <= 1'b0;
            l2send_bus_cmd   <= 3'd0;
            l2send_bus_tag   <= 5'd0;
            l2send_bus_addr  <= 30'd0;
            l2send_bus_data  <= 64'd0;
        end
    end

`ifdef L2SEND_NACKCNT_EN
    logic [15:0] nackcnt_r;

    always_ff @(posedge clk) begin
        if (rst)
            nackcnt_r <= 16'd0;
        else if ((state_r == S_XMIT) && frame_end && nack_r && (nackcnt_r != 16'hFFFF))
            nackcnt_r <= nackcnt_r + 16'd1;
    end

    assign l2send_nackcnt = nackcnt_r;
`endif

endmodule

// File: tb/tb_l2send.sv
// tb_l2send: directed phases plus randomized traffic for l2send, checked against a transaction-level model.
module tb_l2send;
    localparam int         NODE_ID   = 1;
    localparam int         NUM_NODES = 4;
    localparam int         QDEPTH    = 2;
    localparam logic [1:0] NODE      = 2'(NODE_ID);

    typedef struct packed {
        logic [2:0]   cmd;
        logic [4:0]   tag;
        logic [25:0]  addr;
        logic [511:0] data;
    } txn_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         l2_l2send_valid;
    logic         l2send_l2_ready;
    logic [2:0]   l2_l2send_cmd;
    logic [4:0]   l2_l2send_tag;
    logic [25:0]  l2_l2send_addr;
    logic [511:0] l2_l2send_data;
    logic         l2send_l2_done;
    logic         l2recv_l2send_free;
    logic [2:0]   l2recv_l2send_freeidx;
    logic         l2send_bus_valid;
    logic [2:0]   l2send_bus_cmd;
    logic [4:0]   l2send_bus_tag;
    logic [29:0]  l2send_bus_addr;
    logic [63:0]  l2send_bus_data;
    logic         bus_nack;
`ifdef L2SEND_NACKCNT_EN
    logic [15:0]  l2send_nackcnt;
`endif

    always #5 clk = ~clk;

    l2send #(.NODE_ID(NODE_ID), .NUM_NODES(NUM_NODES), .QDEPTH(QDEPTH)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .l2_l2send_valid       (l2_l2send_valid),
        .l2send_l2_ready       (l2send_l2_ready),
        .l2_l2send_cmd         (l2_l2send_cmd),
        .l2_l2send_tag         (l2_l2send_tag),
        .l2_l2send_addr        (l2_l2send_addr),
        .l2_l2send_data        (l2_l2send_data),
        .l2send_l2_done        (l2send_l2_done),
        .l2recv_l2send_free    (l2recv_l2send_free),
        .l2recv_l2send_freeidx (l2recv_l2send_freeidx),
        .l2send_bus_valid      (l2send_bus_valid),
        .l2send_bus_cmd        (l2send_bus_cmd),
        .l2send_bus_tag        (l2send_bus_tag),
        .l2send_bus_addr       (l2send_bus_addr),
        .l2send_bus_data       (l2send_bus_data),
        .bus_nack              (bus_nack)
`ifdef L2SEND_NACKCNT_EN
        ,
        .l2send_nackcnt        (l2send_nackcnt)
`endif
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Transaction-level reference model: queue contents, tag pool, and the frame currently on the bus.
    txn_t       mq[$];
    txn_t       pend[$];
    bit         mfree[8];
    bit         m_held;
    int         m_held_idx;
    bit         m_active;
    bit         m_nacked;
    txn_t       m_tx;
    logic [4:0] m_bus_tag;
    int         m_t;
    int         m_nackcnt;
    int         g_t = 0;

    bit         drv_rst = 1'b0;
    bit         drv_free = 1'b0;
    int         drv_freeidx = 0;
    int         nack_mode = 0;
    int         nack_shots = 0;
    int         free_rate = 0;
    bit         push_random = 1'b0;

    int         last_valid_t = -1;
    int         last_valid_g = 0;
    int         last_done_t = -1;
    int         beat_count = 0;
    logic [4:0] last_tag = '0;
    logic [4:0] last_rd_tag = '0;
    logic [29:0] last_addr = '0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h (t=%0d)", name, obs, exp, m_t);
        end
    endtask

    function automatic bit own_frame(input int t);
        return ((t / 8) % NUM_NODES) == NODE_ID;
    endfunction

    function automatic txn_t mk(input logic [2:0] cmd, input logic [25:0] addr);
        txn_t x;
        x.cmd  = cmd;
        x.addr = addr;
        x.tag  = 5'($urandom);
        for (int i = 0; i < 16; i++) x.data[i*32 +: 32] = $urandom;
        return x;
    endfunction

    function automatic txn_t mk_beats(input logic [2:0] cmd, input logic [25:0] addr);
        txn_t x;
        x = mk(cmd, addr);
        for (int i = 0; i < 8; i++) x.data[i*64 +: 64] = 64'hA0 + 64'(i);
        return x;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 8; i++) mfree[i] = 1'b1;
        m_held    = 1'b0;
        m_held_idx = 0;
        m_active  = 1'b0;
        m_nacked  = 1'b0;
        m_t       = 0;
        m_nackcnt = 0;
    endtask

    // One clock cycle: compare DUT outputs with the model, drive inputs, advance the model.
    task automatic tick();
        int         cyc, idx, fidx;
        bit         is_data, drive, accepted, do_free, is_rd, ok;
        txn_t       p, h;
        int         busy[$];
        logic [63:0] exp_data;

        cyc     = m_t % 8;
        is_data = m_active && (m_tx.cmd == 3'd3 || m_tx.cmd == 3'd4);
        drive   = m_active && (is_data || cyc == 0);
        exp_data = (drive && is_data) ? m_tx.data[cyc*64 +: 64] : 64'd0;

        check("ready", 64'(l2send_l2_ready), 64'(mq.size() < QDEPTH));
        check("done",  64'(l2send_l2_done),  64'(m_active && cyc == 7 && !m_nacked));
        check("valid", 64'(l2send_bus_valid), 64'(drive));
        check("cmd",   64'(l2send_bus_cmd),  drive ? 64'(m_tx.cmd) : 64'd0);
        check("tag",   64'(l2send_bus_tag),  drive ? 64'(m_bus_tag) : 64'd0);
        check("addr",  64'(l2send_bus_addr), drive ? 64'({m_tx.addr, 3'(cyc), 1'b0}) : 64'd0);
        check("data",  l2send_bus_data,      exp_data);
`ifdef L2SEND_NACKCNT_EN
        check("nackcnt", 64'(l2send_nackcnt), 64'(m_nackcnt));
`endif

        if (l2send_bus_valid === 1'b1) begin
            last_valid_t = m_t;
            last_valid_g = g_t;
            last_tag     = l2send_bus_tag;
            last_addr    = l2send_bus_addr;
            beat_count++;
            if (l2send_bus_cmd === 3'd0) last_rd_tag = l2send_bus_tag;
        end
        if (l2send_l2_done === 1'b1) last_done_t = m_t;

        rst = drv_rst;

        if (m_active && cyc == 2) begin
            case (nack_mode)
                1: bus_nack = ($urandom_range(3) == 0);
                2: begin
                    bus_nack = (nack_shots > 0);
                    if (nack_shots > 0) nack_shots--;
                end
                default: bus_nack = 1'b0;
            endcase
        end else begin
            bus_nack = (nack_mode != 0) ? 1'($urandom_range(1)) : 1'b0;
        end

        do_free = 1'b0;
        fidx    = 0;
        if (drv_free) begin
            do_free = 1'b1;
            fidx    = drv_freeidx;
        end else if (free_rate > 0 && $urandom_range(free_rate - 1) == 0) begin
            for (int i = 0; i < 8; i++)
                if (!mfree[i] && !(m_held && m_held_idx == i)) busy.push_back(i);
            if (busy.size() > 0) begin
                do_free = 1'b1;
                fidx    = busy[$urandom_range(busy.size() - 1)];
            end
        end
        l2recv_l2send_free    = do_free;
        l2recv_l2send_freeidx = do_free ? 3'(fidx) : 3'($urandom);

        p = mk(3'($urandom_range(4)), 26'($urandom));
        l2_l2send_valid = 1'b0;
        if (pend.size() > 0 && (!push_random || $urandom_range(1) == 1)) begin
            p = pend[0];
            l2_l2send_valid = 1'b1;
        end
        l2_l2send_cmd  = p.cmd;
        l2_l2send_tag  = p.tag;
        l2_l2send_addr = p.addr;
        l2_l2send_data = p.data;
        accepted = l2_l2send_valid && (mq.size() < QDEPTH) && !drv_rst;
        if (accepted) void'(pend.pop_front());

        if (drv_rst) begin
            model_reset();
        end else begin
            if (m_active && cyc == 2) m_nacked = bus_nack;
            if (cyc == 7) begin
                if (m_active) begin
                    if (!m_nacked) begin
                        void'(mq.pop_front());
                        m_held = 1'b0;
                    end else if (m_nackcnt < 16'hFFFF) begin
                        m_nackcnt++;
                    end
                end
                m_active = 1'b0;
                if (own_frame(m_t + 1) && mq.size() > 0) begin
                    h     = mq[0];
                    is_rd = (h.cmd <= 3'd1);
                    idx   = m_held_idx;
                    ok    = 1'b1;
                    if (is_rd && !m_held) begin
                        ok = 1'b0;
                        for (int i = 7; i >= 0; i--)
                            if (mfree[i]) begin
                                ok  = 1'b1;
                                idx = i;
                            end
                    end
                    if (ok) begin
                        if (is_rd && !m_held) begin
                            mfree[idx] = 1'b0;
                            m_held     = 1'b1;
                            m_held_idx = idx;
                        end
                        m_active = 1'b1;
                        m_nacked = 1'b0;
                        m_tx     = h;
                        if (is_rd)               m_bus_tag = {NODE, idx[2:0]};
                        else if (h.cmd == 3'd3)  m_bus_tag = h.tag;
                        else                     m_bus_tag = {NODE, 3'b000};
                    end
                end
            end
            if (accepted) mq.push_back(p);
            if (do_free) mfree[fidx] = 1'b1;
            m_t++;
        end
        g_t++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_idle(input string name, input int limit);
        int k = 0;
        while ((pend.size() > 0 || mq.size() > 0 || m_active) && k < limit) begin
            tick();
            k++;
        end
        check(name, 64'(k < limit), 64'd1);
    endtask

    task automatic free_all();
        for (int i = 0; i < 8; i++) begin
            if (!mfree[i]) begin
                drv_free    = 1'b1;
                drv_freeidx = i;
                tick();
                drv_free    = 1'b0;
            end
        end
    endtask

    initial begin
        int k;
        rst = 1'b1;
        l2_l2send_valid = 1'b0;
        l2_l2send_cmd = '0;
        l2_l2send_tag = '0;
        l2_l2send_addr = '0;
        l2_l2send_data = '0;
        l2recv_l2send_free = 1'b0;
        l2recv_l2send_freeidx = '0;
        bus_nack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_ready", 64'(l2send_l2_ready), 64'd1);
        check("rst_valid", 64'(l2send_bus_valid), 64'd0);
        check("rst_done",  64'(l2send_l2_done), 64'd0);

        // BUSRD pushed at cyc 3 of frame 0 goes out at cycle 8 and completes at cycle 15.
        run(3);
        pend.push_back(mk(3'd0, 26'h123));
        run(21);
        check("busrd_beat0_t", 64'(last_valid_t), 64'd8);
        check("busrd_tag",     64'(last_tag), 64'(5'b01000));
        check("busrd_addr",    64'(last_addr), 64'({26'h123, 4'b0000}));
        check("busrd_done_t",  64'(last_done_t), 64'd15);

        // BUSRDX nacked three times is retried with the same tag, then completes.
        nack_mode  = 2;
        nack_shots = 3;
        beat_count = 0;
        pend.push_back(mk(3'd1, 26'($urandom)));
        wait_idle("nack_drain", 300);
        check("nack_beats", 64'(beat_count), 64'd4);
        check("nack_tag",   64'(last_tag), 64'(5'b01001));
`ifdef L2SEND_NACKCNT_EN
        check("nackcnt_3", 64'(l2send_nackcnt), 64'd3);
`endif
        nack_mode = 0;
        free_all();

        // FLUSH with beats A0..A7.
        pend.push_back(mk_beats(3'd4, 26'h2A5));
        beat_count = 0;
        wait_idle("flush_drain", 100);
        check("flush_beats", 64'(beat_count), 64'd8);

        // Tag exhaustion: eight BUSRDs take idx 0..7, the ninth stalls until idx 3 is freed.
        for (int i = 0; i < 9; i++) pend.push_back(mk(3'd0, 26'($urandom)));
        run(420);
        check("stall_idle", 64'((g_t - last_valid_g) > 64), 64'd1);
        check("stall_last", 64'(last_rd_tag), 64'(5'b01111));
        drv_free    = 1'b1;
        drv_freeidx = 3;
        tick();
        drv_free    = 1'b0;
        wait_idle("ninth_drain", 200);
        check("ninth_tag", 64'(last_rd_tag), 64'(5'b01011));
        free_all();

        // Queue fills to QDEPTH and deasserts ready.
        for (int i = 0; i < 3; i++) pend.push_back(mk(3'd2, 26'($urandom)));
        run(2);
        check("full_ready", 64'(l2send_l2_ready), 64'd0);
        wait_idle("full_drain", 200);

        // Reset at beat 4 of a FLUSH frame, then a fresh BUSRD takes tag idx 0.
        pend.push_back(mk_beats(3'd4, 26'h0F0));
        k = 0;
        while (!(m_active && (m_t % 8) == 4) && k < 100) begin
            tick();
            k++;
        end
        check("flush_reach", 64'(k < 100), 64'd1);
        drv_rst = 1'b1;
        tick();
        drv_rst = 1'b0;
        check("abort_ready", 64'(l2send_l2_ready), 64'd1);
        check("abort_valid", 64'(l2send_bus_valid), 64'd0);
        pend.push_back(mk(3'd0, 26'($urandom)));
        wait_idle("repush_drain", 100);
        check("repush_tag", 64'(last_rd_tag), 64'(5'b01000));

        // Randomized traffic with random nacks and tag returns.
        push_random = 1'b1;
        free_rate   = 6;
        nack_mode   = 1;
        for (int i = 0; i < 1500; i++) begin
            if (pend.size() < 2 && $urandom_range(3) == 0)
                pend.push_back(mk(3'($urandom_range(4)), 26'($urandom)));
            tick();
        end
        nack_mode = 0;
        wait_idle("random_drain", 2000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
